// File: rtl/koopa_sprite_pkg.sv
// Shared constants and types for the koopa sprite path (walk FSM and sprite fetch).
// Frame geometry defaults, sheet origins of the walk frames, and the fetch FSM state type.
package koopa_sprite_pkg;

    localparam int SPR_W_DEF       = 23;
    localparam int SPR_H_DEF       = 30;
    localparam int SHEET_W_DEF     = 46;
    localparam int TRANSPARENT_DEF = 0;

    // Walk frame origins in the sheet; the walk FSM picks one row/col pair per frame.
    localparam logic [5:0] WALK_ROW_A = 6'd30;
    localparam logic [5:0] WALK_ROW_B = 6'd60;
    localparam logic [5:0] WALK_COL_A = 6'd0;
    localparam logic [5:0] WALK_COL_B = 6'd23;

    localparam logic [0:0] ST_WAIT_FRAME = 1'b0;
    localparam logic [0:0] ST_ACTIVE     = 1'b1;

    typedef enum logic [0:0] {
        WAIT_FRAME = ST_WAIT_FRAME,
        ACTIVE     = ST_ACTIVE
    } fetch_state_t;

    function automatic logic [31:0] sheet_addr(input logic [31:0] row,
                                               input logic [31:0] col,
                                               input logic [31:0] pitch);
        return row * pitch + col;
    endfunction

endpackage

// File: rtl/koopa_sprite_fetch_hit_calc.sv
// Combinational stage 0 of the sprite fetch: sprite-relative offsets, bounds check,
// optional horizontal mirroring and sprite-sheet address arithmetic.
module sprite_hit_calc
    import koopa_sprite_pkg::*;
#(
    parameter int SPR_W   = SPR_W_DEF,
    parameter int SPR_H   = SPR_H_DEF,
    parameter int SHEET_W = SHEET_W_DEF,
    parameter int ADDR_W  = 13
) (
    input  logic              active_i,
    input  logic              mirror_i,
    input  logic [5:0]        row_i,
    input  logic [5:0]        col_i,
    input  logic [9:0]        obj_x_i,
    input  logic [9:0]        obj_y_i,
    input  logic [9:0]        draw_x_i,
    input  logic [9:0]        draw_y_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic signed [10:0] DX_MAX = 11'(SPR_W - 1);
    localparam logic signed [10:0] DY_MAX = 11'(SPR_H - 1);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] dxm;
    logic               in_x;
    logic               in_y;

    // 11-bit signed differences: a raster position left of / above the sprite, or on the
    // far side of a screen-edge wrap, stays negative and can never alias into range.
    always_comb begin
        dx   = $signed({1'b0, draw_x_i}) - $signed({1'b0, obj_x_i});
        dy   = $signed({1'b0, draw_y_i}) - $signed({1'b0, obj_y_i});
        in_x = (dx >= 11'sd0) && (dx <= DX_MAX);
        in_y = (dy >= 11'sd0) && (dy <= DY_MAX);
        hit_o = active_i && in_x && in_y;
        dxm  = mirror_i ? (DX_MAX - dx) : dx;
    end

    always_comb begin
        addr_o = ADDR_W'(sheet_addr(32'(row_i) + 32'($unsigned(dy)),
                                    32'(col_i) + 32'($unsigned(dxm)),
                                    32'(SHEET_W)));
    end

endmodule

// File: rtl/koopa_sprite_fetch.sv
// Sprite fetch: per-frame shadow of the walk frame origin and koopa position, fixed-latency
// pipeline around a synchronous sprite ROM. Mirroring is built only with KOOPA_MIRROR_EN.
//
// state      | meaning
// WAIT_FRAME | no frame sampled since reset; pixels flow but always miss
// ACTIVE     | shadow registers hold a sampled frame; normal hit testing
module koopa_sprite_fetch
    import koopa_sprite_pkg::*;
#(
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int SHEET_W     = SHEET_W_DEF,
    parameter int ADDR_W      = 13,
    parameter int PIX_W       = 4,
    parameter int TRANSPARENT = TRANSPARENT_DEF,
    parameter int ROM_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [5:0]        anim_row,
    input  logic [5:0]        anim_col,
    input  logic [9:0]        obj_x,
    input  logic [9:0]        obj_y,
    input  logic              facing_left,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_out_valid,
    output logic [PIX_W-1:0]  pix_index,
    output logic              pix_opaque
);

    localparam logic [PIX_W-1:0] TRANSP_IDX = PIX_W'(TRANSPARENT);

    fetch_state_t      state_q, state_d;
    logic [5:0]        row_q, row_d;
    logic [5:0]        col_q, col_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              mirror_s;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]  vld_q, vld_d;
    logic [ROM_LAT:0]  hit_q, hit_d;
    logic              out_vld_q, out_vld_d;
    logic [PIX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_opq_q, out_opq_d;
    logic              hit_s0;
    logic [ADDR_W-1:0] addr_s0;
    logic              tail_hit;

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ACTIVE;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        x_d   = x_q;
        y_d   = y_q;
        if (frame_start) begin
            row_d = anim_row;
            col_d = anim_col;
            x_d   = obj_x;
            y_d   = obj_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
            row_q   <= WALK_ROW_A;
            col_q   <= WALK_COL_A;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

`ifdef KOOPA_MIRROR_EN
    logic mirror_q, mirror_d;

    always_comb begin
        mirror_d = frame_start ? facing_left : mirror_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mirror_q <= 1'b0;
        end else begin
            mirror_q <= mirror_d;
        end
    end

    assign mirror_s = mirror_q;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign mirror_s      = 1'b0;
`endif

    sprite_hit_calc #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .SHEET_W (SHEET_W),
        .ADDR_W  (ADDR_W)
    ) u_hit_calc (
        .active_i (state_q == ACTIVE),
        .mirror_i (mirror_s),
        .row_i    (row_q),
        .col_i    (col_q),
        .obj_x_i  (x_q),
        .obj_y_i  (y_q),
        .draw_x_i (draw_x),
        .draw_y_i (draw_y),
        .hit_o    (hit_s0),
        .addr_o   (addr_s0)
    );

    // rom_addr only moves on a real hit so the ROM address bus stays quiet elsewhere.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (pix_valid && hit_s0) begin
            rom_addr_d = addr_s0;
        end
    end

    always_comb begin
        vld_d    = '0;
        hit_d    = '0;
        vld_d[0] = pix_valid;
        hit_d[0] = pix_valid && hit_s0;
        for (int i = 1; i <= ROM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            hit_d[i] = hit_q[i-1];
        end
    end

    assign tail_hit = vld_q[ROM_LAT] && hit_q[ROM_LAT];

    always_comb begin
        out_vld_d = vld_q[ROM_LAT];
        out_idx_d = '0;
        out_opq_d = 1'b0;
        if (tail_hit) begin
            out_idx_d = rom_data;
            out_opq_d = (rom_data != TRANSP_IDX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            vld_q      <= '0;
            hit_q      <= '0;
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            out_opq_q  <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            hit_q      <= hit_d;
            out_vld_q  <= out_vld_d;
            out_idx_q  <= out_idx_d;
            out_opq_q  <= out_opq_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign pix_out_valid = out_vld_q;
    assign pix_index     = out_idx_q;
    assign pix_opaque    = out_opq_q;

endmodule

// File: tb/tb_koopa_sprite_fetch.sv
// Self-checking bench for koopa_sprite_fetch: directed scenarios plus randomized raster
// traffic against a behavioural model; honours KOOPA_MIRROR_EN like the design.
module tb_koopa_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [5:0]  anim_row;
    logic [5:0]  anim_col;
    logic [9:0]  obj_x;
    logic [9:0]  obj_y;
    logic        facing_left;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        pix_valid;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data;
    logic        pix_out_valid;
    logic [3:0]  pix_index;
    logic        pix_opaque;

`ifdef KOOPA_MIRROR_EN
    localparam bit MIRROR_ON = 1'b1;
`else
    localparam bit MIRROR_ON = 1'b0;
`endif

    logic [3:0] rom [0:8191];

    int n_checks = 0;
    int n_pass   = 0;
    int gcyc     = 0;

    // Expected output of the pixel presented in each cycle (ring indexed by cycle).
    bit         exp_v   [0:4095];
    bit         exp_op  [0:4095];
    logic [3:0] exp_idx [0:4095];

    int sh_row = 30, sh_col = 0, sh_x = 0, sh_y = 0;
    bit sh_m = 1'b0, m_active = 1'b0;
    int exp_raddr = 0;

    koopa_sprite_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .anim_row      (anim_row),
        .anim_col      (anim_col),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .facing_left   (facing_left),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .pix_valid     (pix_valid),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pix_out_valid (pix_out_valid),
        .pix_index     (pix_index),
        .pix_opaque    (pix_opaque)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic model_reset();
        sh_row = 30; sh_col = 0; sh_x = 0; sh_y = 0; sh_m = 1'b0;
        m_active = 1'b0; exp_raddr = 0;
        for (int i = 0; i < 4096; i++) exp_v[i] = 1'b0;
    endtask

    // Present one raster cycle, record what the sprite rules say it must produce, clock it.
    task automatic tick(input bit fs, input bit v, input int x, input int y);
        int dx, dy, dxm, a, k;
        bit h;
        frame_start = fs; pix_valid = v;
        draw_x = 10'(x); draw_y = 10'(y);
        dx = (x & 1023) - sh_x;
        dy = (y & 1023) - sh_y;
        h  = v && m_active && dx >= 0 && dx < 23 && dy >= 0 && dy < 30;
        dxm = (MIRROR_ON && sh_m) ? 22 - dx : dx;
        k = gcyc % 4096;
        exp_v[k] = v; exp_idx[k] = 4'd0; exp_op[k] = 1'b0;
        if (h) begin
            a = ((sh_row + dy) * 46 + sh_col + dxm) % 8192;
            exp_idx[k] = rom[a];
            exp_op[k]  = (rom[a] != 4'd0);
            exp_raddr  = a;
        end
        if (fs) begin
            sh_row = int'(anim_row); sh_col = int'(anim_col);
            sh_x = int'(obj_x); sh_y = int'(obj_y); sh_m = facing_left;
            m_active = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0; pix_valid = 1'b0;
        gcyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (rom_addr !== 13'd0) $display("FAIL reset_addr: got %0d want 0", rom_addr); else n_pass++;
        n_checks++; if (pix_out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", pix_out_valid); else n_pass++;
        n_checks++; if (pix_index !== 4'd0) $display("FAIL reset_index: got %0d want 0", pix_index); else n_pass++;
        n_checks++; if (pix_opaque !== 1'b0) $display("FAIL reset_opaque: got %0b want 0", pix_opaque); else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_pre_frame();
        obj_x = 10'd100; obj_y = 10'd100;
        tick(0, 1, 100, 100);
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b0) $display("FAIL pre_frame_early: valid=%0b want 0", pix_out_valid); else n_pass++;
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b1) $display("FAIL pre_frame_valid: got %0b want 1", pix_out_valid); else n_pass++;
        n_checks++; if (pix_opaque !== 1'b0 || pix_index !== 4'd0)
            $display("FAIL pre_frame_miss: opaque=%0b index=%0d want 0/0", pix_opaque, pix_index); else n_pass++;
    endtask

    task automatic test_basic_hit();
        rom[1380] = 4'd5;
        anim_row = 6'd30; anim_col = 6'd0; obj_x = 10'd100; obj_y = 10'd50; facing_left = 1'b0;
        tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        n_checks++; if (rom_addr !== 13'd1380) $display("FAIL basic_addr: got %0d want 1380", rom_addr); else n_pass++;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b1 || pix_index !== 4'd5 || pix_opaque !== 1'b1)
            $display("FAIL basic_out: valid=%0b index=%0d opaque=%0b want 1/5/1", pix_out_valid, pix_index, pix_opaque);
        else n_pass++;
    endtask

    task automatic test_bounds();
        rom[2736] = 4'd7;
        tick(0, 1, 122, 79);
        n_checks++; if (rom_addr !== 13'd2736) $display("FAIL bounds_corner_addr: got %0d want 2736", rom_addr); else n_pass++;
        tick(0, 1, 123, 79);
        n_checks++; if (rom_addr !== 13'd2736) $display("FAIL bounds_hold_addr: got %0d want 2736", rom_addr); else n_pass++;
        tick(0, 1, 99, 50);
        n_checks++; if (pix_out_valid !== 1'b1 || pix_index !== 4'd7 || pix_opaque !== 1'b1)
            $display("FAIL bounds_corner_out: valid=%0b index=%0d opaque=%0b want 1/7/1", pix_out_valid, pix_index, pix_opaque);
        else n_pass++;
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b1 || pix_index !== 4'd0 || pix_opaque !== 1'b0)
            $display("FAIL bounds_right_miss: valid=%0b index=%0d opaque=%0b want 1/0/0", pix_out_valid, pix_index, pix_opaque);
        else n_pass++;
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b1 || pix_opaque !== 1'b0)
            $display("FAIL bounds_neg_dx: valid=%0b opaque=%0b want 1/0", pix_out_valid, pix_opaque);
        else n_pass++;
        tick(0, 0, 0, 0);
    endtask

    task automatic test_mirror();
        logic [12:0] want0, want1;
        want0 = MIRROR_ON ? 13'd1425 : 13'd1403;
        want1 = MIRROR_ON ? 13'd1403 : 13'd1425;
        anim_row = 6'd30; anim_col = 6'd23; facing_left = 1'b1;
        tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        n_checks++; if (rom_addr !== want0) $display("FAIL mirror_left_edge: got %0d want %0d", rom_addr, want0); else n_pass++;
        tick(0, 1, 122, 50);
        n_checks++; if (rom_addr !== want1) $display("FAIL mirror_right_edge: got %0d want %0d", rom_addr, want1); else n_pass++;
        anim_col = 6'd0; facing_left = 1'b0;
        tick(1, 0, 0, 0);
    endtask

    task automatic test_tearing();
        anim_row = 6'd60;
        tick(0, 1, 100, 50);
        n_checks++; if (rom_addr !== 13'd1380) $display("FAIL tear_no_load: got %0d want 1380", rom_addr); else n_pass++;
        tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        n_checks++; if (rom_addr !== 13'd2760) $display("FAIL tear_reload: got %0d want 2760", rom_addr); else n_pass++;
        anim_row = 6'd30;
        tick(1, 1, 101, 50);
        n_checks++; if (rom_addr !== 13'd2761) $display("FAIL tear_coincident_old: got %0d want 2761", rom_addr); else n_pass++;
        tick(0, 1, 101, 50);
        n_checks++; if (rom_addr !== 13'd1381) $display("FAIL tear_coincident_new: got %0d want 1381", rom_addr); else n_pass++;
    endtask

    task automatic test_random();
        int k, ox, oy, px, py;
        for (int i = 0; i < 400; i++) begin
            bit fs, v;
            fs = ($urandom_range(0, 24) == 0);
            if (fs) begin
                anim_row = 6'($urandom_range(0, 63));
                anim_col = 6'($urandom_range(0, 63));
                ox = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
                oy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
                obj_x = 10'(ox); obj_y = 10'(oy);
                facing_left = 1'($urandom_range(0, 1));
            end
            v  = ($urandom_range(0, 3) != 0);
            px = (sh_x + int'($urandom_range(0, 40)) - 8) & 1023;
            py = (sh_y + int'($urandom_range(0, 44)) - 8) & 1023;
            tick(fs, v, px, py);
            k = (gcyc - 3) % 4096;
            n_checks++; if (rom_addr !== 13'(exp_raddr))
                $display("FAIL rand_addr cyc %0d: got %0d want %0d", gcyc, rom_addr, exp_raddr); else n_pass++;
            n_checks++; if (pix_out_valid !== exp_v[k] || pix_index !== exp_idx[k] || pix_opaque !== exp_op[k])
                $display("FAIL rand_out cyc %0d: valid=%0b index=%0d opaque=%0b want %0b/%0d/%0b",
                         gcyc, pix_out_valid, pix_index, pix_opaque, exp_v[k], exp_idx[k], exp_op[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        anim_row = 6'd30; anim_col = 6'd0; obj_x = 10'd100; obj_y = 10'd50; facing_left = 1'b0;
        tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        tick(0, 1, 101, 50);
        tick(0, 1, 102, 50);
        n_checks++; if (pix_out_valid !== 1'b1) $display("FAIL flight_before_reset: valid=%0b want 1", pix_out_valid); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (pix_out_valid !== 1'b0 || pix_index !== 4'd0 || pix_opaque !== 1'b0)
            $display("FAIL flight_async_clear: valid=%0b index=%0d opaque=%0b want 0/0/0", pix_out_valid, pix_index, pix_opaque);
        else n_pass++;
        n_checks++; if (rom_addr !== 13'd0) $display("FAIL flight_addr_clear: got %0d want 0", rom_addr); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            n_checks++; if (pix_out_valid !== 1'b0) $display("FAIL flight_stale_out %0d: valid=%0b want 0", i, pix_out_valid); else n_pass++;
        end
        rom[5 * 46 + 5] = 4'd9;
        tick(0, 1, 5, 5);
        n_checks++; if (rom_addr !== 13'd0) $display("FAIL flight_wait_frame_addr: got %0d want 0", rom_addr); else n_pass++;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++; if (pix_out_valid !== 1'b1 || pix_opaque !== 1'b0)
            $display("FAIL flight_wait_frame_miss: valid=%0b opaque=%0b want 1/0", pix_out_valid, pix_opaque);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 4'($urandom_range(0, 15));
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; facing_left = 1'b0;
        anim_row = '0; anim_col = '0; obj_x = '0; obj_y = '0; draw_x = '0; draw_y = '0;
        test_reset();
        test_pre_frame();
        test_basic_hit();
        test_bounds();
        test_mirror();
        test_tearing();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/koopa_sprite_fetch.md
Name: koopa_sprite_fetch

Overview:
- Downstream consumer of the koopa walk animation FSM: takes the selected frame origin (anim_row, anim_col) plus the koopa's screen position.
- Generates sprite-sheet ROM addresses for every pixel the raster scan presents, and returns a palette index and opaque flag to the pixel mux.
- Frame origin and position are sampled once per video frame so the sprite never tears mid-scan.
- Fixed-latency valid pipeline that wraps a synchronous ROM.

Parameters:
- SPR_W, 23, sprite frame width in pixels (column offset between walk frames)
- SPR_H, 30, sprite frame height in pixels
- SHEET_W, 46, sprite sheet row pitch in pixels
- ADDR_W, 13, ROM address width (covers 90 rows x 46 pitch = 4140 words)
- PIX_W, 4, palette index width
- TRANSPARENT, 0, palette index treated as see-through
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- anim_row  in  6  sprite frame top row in sheet (from walk FSM)
- anim_col  in  6  sprite frame left column in sheet
- obj_x  in  10  koopa screen X (left edge)
- obj_y  in  10  koopa screen Y (top edge)
- facing_left  in  1  draw horizontally mirrored
- draw_x  in  10  current raster X
- draw_y  in  10  current raster Y
- pix_valid  in  1  draw_x/draw_y valid this cycle
- rom_addr  out  ADDR_W  sprite ROM read address (registered)
- rom_data  in  PIX_W  ROM read data, ROM_LAT cycles after rom_addr
- pix_out_valid  out  1  result valid
- pix_index  out  PIX_W  palette index
- pix_opaque  out  1  koopa pixel covers background

Behaviour:
- Reset (async, immediate): state=WAIT_FRAME; shadow row=30, col=0, x=0, y=0, mirror=0; rom_addr=0; all pipeline valids=0; pix_out_valid=0, pix_index=0, pix_opaque=0.
- FSM states:
  - WAIT_FRAME: no frame sampled yet. Pipeline runs, but hit is forced to 0.
  - ACTIVE: normal operation.
  - WAIT_FRAME->ACTIVE on the first frame_start. ACTIVE stays ACTIVE. Only reset returns to WAIT_FRAME.
- Shadow load: on frame_start (any state), register anim_row, anim_col, obj_x, obj_y and facing_left. The load is visible to pixels presented the cycle after the pulse. Inputs changing at other times are ignored.
- Stage 0 (cycle N, pix_valid=1):
  - dx = draw_x - obj_x and dy = draw_y - obj_y, computed 11-bit signed.
  - hit = ACTIVE & dx in [0, SPR_W-1] & dy in [0, SPR_H-1]. Negative results and screen-edge wrap produce miss, never an alias.
  - Mirroring: dxm = SPR_W-1-dx when mirror, else dx.
  - Address = (row_s + dy) * SHEET_W + col_s + dxm, truncated to ADDR_W.
  - rom_addr is registered at the end of N. On a miss or pix_valid=0, rom_addr holds its previous value.
- Valid/hit travel in a shift register of depth 1+ROM_LAT. Output is registered: pix_out_valid asserts at N+2+ROM_LAT (3 cycles at default).
- Output values:
  - On a hit: pix_index=rom_data, pix_opaque=(rom_data!=TRANSPARENT).
  - On a miss: pix_index=0, pix_opaque=0.
  - pix_out_valid=0 cycles: pix_index and pix_opaque are driven 0.
- Back-to-back pixels every cycle are supported; throughput 1 pixel/cycle, no stall input.
- frame_start coincident with pix_valid: the pixel in that cycle uses the old shadow values.
- Reset mid-pipeline clears all in-flight valids; no stale output is emitted.

Optional Feature:
- KOOPA_MIRROR_EN.
  - Defined: facing_left is sampled and mirrors dx as above.
  - Undefined: facing_left is ignored, the mirror register is absent and dxm=dx. The port remains so instantiation is unchanged.

Decomposition:
- Shared package koopa_sprite_pkg holds:
  - SPR_W, SPR_H, SHEET_W and TRANSPARENT default constants.
  - The fetch_state_t enum (WAIT_FRAME, ACTIVE), 1 bit.
  - Walk frame origin constants (rows 30/60, cols 0/23) shared with the walk FSM.
- One sub-module: sprite_hit_calc, the combinational stage-0 bounds check, mirroring and address arithmetic. The pipeline and FSM stay in the top module.

Test Plan:
- Pre-frame: reset, then pix_valid=1 at (100,100) with obj at (100,100) and no frame_start -> pix_out_valid=1 at N+3, pix_opaque=0.
- Basic hit: frame_start with row=30, col=0, obj=(100,50); pixel (100,50) -> rom_addr=1380 at N+1; rom_data=5 -> pix_index=5, pix_opaque=1 at N+3.
- Bounds: with obj=(100,50), pixels (122,79) and (123,79) -> first hits with addr=59*46+22=2736; second misses with opaque=0. Pixel (99,50) -> miss (negative dx).
- Mirror (KOOPA_MIRROR_EN defined): facing_left=1, col=23, pixel (100,50) -> addr=30*46+23+22=1425. With macro undefined -> addr=1403.
- Tearing: change anim_row to 60 mid-frame with no frame_start -> addresses still use row 30. After the next frame_start pulse -> pixel (100,50) gives 2760.
- Reset with 3 pixels in flight -> pix_out_valid=0 immediately; no output on the following cycles.
